// File: rtl/alu_pkg.sv
// Shared opcode encodings for the execute-stage ALU.
package alu_pkg;

  localparam int unsigned OpWidth = 3;

  localparam logic [OpWidth-1:0] ADD = 3'b000;
  localparam logic [OpWidth-1:0] SUB = 3'b001;
  localparam logic [OpWidth-1:0] AND = 3'b010;
  localparam logic [OpWidth-1:0] OR  = 3'b011;
  localparam logic [OpWidth-1:0] XOR = 3'b100;
  localparam logic [OpWidth-1:0] NOT = 3'b101;
  localparam logic [OpWidth-1:0] SHL = 3'b110;
  localparam logic [OpWidth-1:0] SHR = 3'b111;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: decodes op into the next result and carry/borrow/shift-out bit.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OpWidth-1:0] op,
  output logic [WIDTH-1:0]   res_d,
  output logic               carry_d
);

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    // Plain case: an op with unknown bits matches no item and falls to the default.
    case (op)
      ADD: {carry_d, res_d} = {1'b0, a} + {1'b0, b};
      // Bit WIDTH of the widened difference is set exactly when a < b.
      SUB: {carry_d, res_d} = {1'b0, a} - {1'b0, b};
      AND: res_d = a & b;
      OR:  res_d = a | b;
      XOR: res_d = a ^ b;
      NOT: res_d = ~a;
      SHL: begin
        res_d   = {a[WIDTH-2:0], 1'b0};
        carry_d = a[WIDTH-1];
      end
      SHR: begin
        res_d   = {1'b0, a[WIDTH-1:1]};
        carry_d = a[0];
      end
      default: begin
        res_d   = '0;
        carry_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational datapath followed by registered result, zero and carry.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OpWidth-1:0] op,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               carry
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;

  alu_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .a      (a),
    .b      (b),
    .op     (op),
    .res_d  (result_d),
    .carry_d(carry_d)
  );

  assign zero_d = (result_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu.sv
// Directed and randomised checks of the registered ALU with a scoreboard queue.
module tb_alu;
  import alu_pkg::*;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [W-1:0]       a, b;
  logic [OpWidth-1:0] op;
  logic [W-1:0]       result;
  logic               zero, carry;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  alu #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .op    (op),
    .result(result),
    .zero  (zero),
    .carry (carry)
  );

  always #5 clk = ~clk;

  // Reference model written in integer arithmetic.
  function automatic exp_t model(input int opi, input int ai, input int bi);
    int r;
    int c;
    exp_t e;
    c = 0;
    case (opi)
      0: begin r = (ai + bi) % 16; c = (ai + bi >= 16) ? 1 : 0; end
      1: begin r = (ai - bi + 16) % 16; c = (ai < bi) ? 1 : 0; end
      2: r = ai & bi;
      3: r = ai | bi;
      4: r = ai ^ bi;
      5: r = 15 - ai;
      6: begin r = (ai * 2) % 16; c = (ai >= 8) ? 1 : 0; end
      default: begin r = ai / 2; c = ai % 2; end
    endcase
    e.res = W'(r);
    e.z   = (r == 0);
    e.c   = (c != 0);
    return e;
  endfunction

  task automatic compare();
    exp_t  e;
    string t;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: got empty queue expected an entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (result === e.res) else begin
        errors++;
        $error("FAIL %s result: got %b expected %b", t, result, e.res);
      end
      checks++;
      assert (zero === e.z) else begin
        errors++;
        $error("FAIL %s zero: got %b expected %b", t, zero, e.z);
      end
      checks++;
      assert (carry === e.c) else begin
        errors++;
        $error("FAIL %s carry: got %b expected %b", t, carry, e.c);
      end
    end
  endtask

  task automatic step(input string t, input logic r, input logic [W-1:0] ai,
                      input logic [W-1:0] bi, input logic [OpWidth-1:0] opi,
                      input logic [W-1:0] er, input logic ez, input logic ec);
    @(negedge clk);
    rst = r;
    a   = ai;
    b   = bi;
    op  = opi;
    exp_q.push_back({er, ez, ec});
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   ai, bi, opi;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    op  = ADD;

    // Reset held for two edges, with a live ADD on the inputs that it must override.
    step("reset1", 1'b1, 4'd5, 4'd3, ADD, 4'b0000, 1'b1, 1'b0);
    step("reset2", 1'b1, 4'd5, 4'd3, ADD, 4'b0000, 1'b1, 1'b0);

    step("add5p3",  1'b0, 4'd5,    4'd3,    ADD, 4'd8,    1'b0, 1'b0);
    step("sub8m3",  1'b0, 4'd8,    4'd3,    SUB, 4'd5,    1'b0, 1'b0);
    step("sub3m8",  1'b0, 4'd3,    4'd8,    SUB, 4'b1011, 1'b0, 1'b1);
    step("and",     1'b0, 4'b1010, 4'b1100, AND, 4'b1000, 1'b0, 1'b0);
    step("or",      1'b0, 4'b1010, 4'b1100, OR,  4'b1110, 1'b0, 1'b0);
    step("xor",     1'b0, 4'b1010, 4'b1100, XOR, 4'b0110, 1'b0, 1'b0);
    step("not",     1'b0, 4'b1010, 4'b1100, NOT, 4'b0101, 1'b0, 1'b0);
    step("shl",     1'b0, 4'b1010, 4'b1100, SHL, 4'b0100, 1'b0, 1'b1);
    step("shr",     1'b0, 4'b1010, 4'b1100, SHR, 4'b0101, 1'b0, 1'b0);
    step("add0p0",  1'b0, 4'd0,    4'd0,    ADD, 4'd0,    1'b1, 1'b0);
    step("add15p1", 1'b0, 4'd15,   4'd1,    ADD, 4'd0,    1'b1, 1'b1);
    step("sub7m7",  1'b0, 4'd7,    4'd7,    SUB, 4'd0,    1'b1, 1'b0);
    step("shr1",    1'b0, 4'b0001, 4'd0,    SHR, 4'd0,    1'b1, 1'b1);
    step("shl8",    1'b0, 4'b1000, 4'd0,    SHL, 4'd0,    1'b1, 1'b1);

    // Leave the flags set so the invalid op must actively clear them.
    step("pre_inv", 1'b0, 4'd15,   4'd15,   ADD, 4'b1110, 1'b0, 1'b1);
    step("inv_op",  1'b0, 4'd0,    4'd0,    3'bxxx, 4'd0, 1'b1, 1'b0);

    // Reset in the middle of a stream of valid ops.
    step("pre_rst", 1'b0, 4'd2,    4'd3,    ADD, 4'd5,    1'b0, 1'b0);
    step("mid_rst", 1'b1, 4'd9,    4'd9,    ADD, 4'd0,    1'b1, 1'b0);
    step("post_rst", 1'b0, 4'd1,   4'd1,    ADD, 4'd2,    1'b0, 1'b0);

    // Back-to-back random ops against the integer model.
    for (int i = 0; i < 24; i++) begin
      ai  = int'($urandom_range(0, 15));
      bi  = int'($urandom_range(0, 15));
      opi = int'($urandom_range(0, 7));
      e   = model(opi, ai, bi);
      step($sformatf("rand%0d_op%0d", i, opi), 1'b0, W'(ai), W'(bi), OpWidth'(opi),
           e.res, e.z, e.c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
